// File: rtl/gray_cnt_sched.sv
// Round-robin scheduler that grants two requesters timed sessions on a shared Gray-coded counter.
// Define GRAY_CNT_SCHED_TIMEOUT_EN to add a 300-cycle RUN watchdog that drives err.
module gray_cnt_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] len0,
    input  logic [7:0] len1,
    input  logic [7:0] count,
    input  logic       overflow,
    output logic       count_clr,
    output logic       count_en,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [7:0] result,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic       winner_q, winner_d;
    logic       lastServed_q, lastServed_d;
    logic [7:0] len_q, len_d;
    logic [7:0] result_q, result_d;
    logic [7:0] bin;
    logic       reqWin;
    logic       finish;
    logic       gntOn;
    logic       doneOn;
    logic       pick;
    logic       timeout;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bin[i] = ^(count >> i);
        end
    end

    assign reqWin = req[winner_q];
    assign finish = (len_q != 8'd0) ? (bin == len_q) : overflow;
    assign pick   = (req == 2'b11) ? ~lastServed_q : req[1];

`ifdef GRAY_CNT_SCHED_TIMEOUT_EN
    logic [8:0] wdog_q, wdog_d;
    logic       tmo_q, tmo_d;

    assign timeout = (wdog_q == 9'd299);
    assign wdog_d  = (state_q == RUN) ? wdog_q + 9'd1 : 9'd0;
    assign err     = (state_q == DONE) && tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 9'd0;
            tmo_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        lastServed_d = lastServed_q;
        len_d        = len_q;
        result_d     = result_q;
        count_clr    = 1'b0;
        count_en     = 1'b0;
        gntOn        = 1'b0;
        doneOn       = 1'b0;
`ifdef GRAY_CNT_SCHED_TIMEOUT_EN
        tmo_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    winner_d = pick;
                    len_d    = pick ? len1 : len0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                gntOn     = 1'b1;
                count_clr = 1'b1;
                if (!reqWin) begin
                    lastServed_d = winner_q;
                    state_d      = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                gntOn = 1'b1;
                // Abort beats completion; the watchdog only fires when nothing else ends the session.
                if (!reqWin) begin
                    lastServed_d = winner_q;
                    state_d      = IDLE;
                end else if (finish || timeout) begin
                    result_d = bin;
                    state_d  = DONE;
`ifdef GRAY_CNT_SCHED_TIMEOUT_EN
                    tmo_d    = ~finish;
`endif
                end else begin
                    count_en = 1'b1;
                end
            end
            DONE: begin
                gntOn        = 1'b1;
                doneOn       = 1'b1;
                lastServed_d = winner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt    = gntOn ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
    assign done   = doneOn ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
    assign result = result_q;

    // Reset leaves requester 1 as last served so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            lastServed_q <= 1'b1;
            len_q        <= 8'd0;
            result_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            lastServed_q <= lastServed_d;
            len_q        <= len_d;
            result_q     <= result_d;
        end
    end

endmodule

// File: doc/gray_cnt_sched.md
GRAY_CNT_SCHED -- requirements
Module: gray_cnt_sched

Interface
REQ-001 SHALL have ports, clock and reset first: clk  input  1  sole clock, rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 req  input  2  per-requester session request, level, held until done or abort.
REQ-004 len0, len1  input  8 each  requested increment count per requester; 0 means run to wrap (256 increments).
REQ-005 count  input  8  Gray-coded value from the shared counter.
REQ-006 overflow  input  1  counter wrap flag.
REQ-007 count_clr  output  1  synchronous clear to the counter.
REQ-008 count_en  output  1  increment enable to the counter.
REQ-009 gnt  output  2  one-hot grant, at most one bit high.
REQ-010 done  output  2  one-cycle completion pulse to the granted requester.
REQ-011 result  output  8  binary counter value latched at session end.
REQ-012 err  output  1  one-cycle timeout pulse; constant 0 unless the REQ-027 macro is defined.

Function
REQ-013 SHALL implement the FSM states IDLE, CLEAR, RUN and DONE.
REQ-014 IDLE: with any req bit high, SHALL latch the winner and its len and go to CLEAR on the next edge.
REQ-015 Arbitration SHALL be round-robin: with both requests high, grant the requester not served last; with one request high, grant it.
REQ-016 The round-robin pointer SHALL update on leaving DONE or on abort.
REQ-017 gnt SHALL be high in CLEAR, RUN and DONE for the latched winner.
REQ-018 CLEAR: count_clr SHALL be 1 and count_en 0 for exactly one cycle, then go to RUN.
REQ-019 RUN: the binary value SHALL be computed as bin = gray-to-binary(count), combinationally.
REQ-020 RUN with len≠0: count_en SHALL be 1 while bin≠len; when bin==len, count_en SHALL be 0 and the FSM goes to DONE.
REQ-021 RUN with len==0: count_en SHALL be 1 while overflow==0; when overflow==1, count_en SHALL be 0 and the FSM goes to DONE.
REQ-022 DONE: result SHALL latch bin, done[winner] pulses for one cycle, and the FSM returns to IDLE.
REQ-023 Latency with a 1-cycle-registered counter SHALL be: req sampled at edge E gives done high after edge E+len+2 (E+258 for len==0).
REQ-024 Abort: if req[winner] falls in CLEAR or RUN, the FSM SHALL go to IDLE on the next edge with count_en=0, gnt=0, no done pulse, and result unchanged.
REQ-025 count_clr and count_en SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and DONE.

Reset
REQ-026 With rst_n low, all outputs SHALL be 0, the FSM in IDLE and the pointer set to "last served = 1" so requester 0 wins the first tie, with the effect immediate and no clock needed; a reset mid-session SHALL abandon the session with no done.

Configuration
REQ-027 Macro GRAY_CNT_SCHED_TIMEOUT_EN SHALL control the RUN watchdog.
REQ-028 With the macro defined: a 9-bit watchdog SHALL clear on entering RUN and count RUN cycles; at 300 cycles with no termination, err pulses, result latches bin, the FSM goes to DONE and done also pulses.
REQ-029 Without the macro: there SHALL be no watchdog logic, err tied 0, and RUN unbounded.

Verification
REQ-030 Single request: req=01, len0=5, model counter -> count_clr for 1 cycle; count_en for 5 cycles; done=01 pulse; result=05; counter holds Gray 07.
REQ-031 Tie: req=11 from reset, len0=2, len1=3 -> gnt=01 first, result=02; then gnt=10, result=03; re-raising both then grants 01.
REQ-032 Wrap: req=10, len1=0 -> 256 enabled cycles; stop on the overflow cycle; result=00; done=10.
REQ-033 Abort: req0 drops in RUN at bin=3 -> count_en=0 next cycle; gnt=00; no done; pending req1 granted from IDLE.
REQ-034 Async reset at bin=4 of a len=10 session -> outputs 0 within 1 ns with no clock edge; no done after release.
REQ-035 (macro defined) Counter stuck (count held at 0), len0=5 -> err and done pulse 300 cycles after RUN entry; result=00.
